// File: rtl/bank_htu_req_arb.sv
// rtl/bank_htu_req_arb.sv - round-robin lookup/allocate request controller for one bank's HTU set-status block.
// Optional macro HTU_ARB_RETRY_LIMIT_EN: bounds "set full" retries to MAX_RETRY and reports resp_err_o.
module bank_htu_req_arb #(
  parameter int NUM_REQ   = 4,
  parameter int RETRY_GAP = 4,
  parameter int MAX_RETRY = 15,
  localparam int IDW      = $clog2(NUM_REQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  input  logic [NUM_REQ*22-1:0] req_tag_i,
  input  logic [NUM_REQ-1:0]    req_offset_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  output logic                  lkp_valid_o,
  output logic [21:0]           lkp_tag_o,
  output logic                  lkp_offset_o,
  input  logic                  lkp_resp_valid_i,
  input  logic                  lkp_resp_hit_i,
  input  logic                  lkp_resp_full_i,
  input  logic [2:0]            lkp_resp_way_i,
  input  logic                  rel_valid_i,
  input  logic [2:0]            rel_way_i,
  output logic                  rel_ready_o,
  output logic                  rel_valid_o,
  output logic [2:0]            rel_way_o,
  output logic                  resp_valid_o,
  output logic [IDW-1:0]        resp_id_o,
  output logic                  resp_hit_o,
  output logic [2:0]            resp_way_o,
  output logic                  resp_err_o,
  input  logic                  resp_ready_i
);

  typedef enum logic [1:0] {IDLE, LOOKUP, RETRY, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant_idx;
  logic           grant_found;
  logic           grant;
  logic           rel_accept;
  logic           full_resp;
  logic           retry_exhausted;
  logic [21:0]    cap_tag;
  logic           cap_offset;
  logic [IDW-1:0] cap_id;
  logic           cap_hit;
  logic [2:0]     cap_way;
  logic [3:0]     gap_cnt;

  // MAX_RETRY is referenced here so it stays visible when the limit is compiled out.
  if (MAX_RETRY > 15) begin : g_max_retry_out_of_range
  end

  // Lowest offset from rr_ptr wins: scan descending so the nearest valid overwrites.
  always_comb begin
    logic [IDW-1:0] idx;
    grant_found = 1'b0;
    grant_idx   = rr_ptr;
    idx         = rr_ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = rr_ptr + IDW'(i);
      if (req_valid_i[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  assign rel_accept = rel_valid_i && (state == IDLE || state == RETRY);
  assign grant      = (state == IDLE) && !rel_valid_i && grant_found;
  assign full_resp  = lkp_resp_valid_i && lkp_resp_full_i;

`ifdef HTU_ARB_RETRY_LIMIT_EN
  logic [3:0] retry_cnt;
  logic       cap_err;

  assign retry_exhausted = (retry_cnt == 4'(MAX_RETRY));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retry_cnt <= 4'd0;
      cap_err   <= 1'b0;
    end else begin
      if (grant) begin
        retry_cnt <= 4'd0;
        cap_err   <= 1'b0;
      end else if (state == LOOKUP && lkp_resp_valid_i) begin
        if (full_resp && !retry_exhausted) begin
          retry_cnt <= retry_cnt + 4'd1;
        end
        cap_err <= full_resp && retry_exhausted;
      end
    end
  end

  assign resp_err_o = cap_err;
`else
  assign retry_exhausted = 1'b0;
  assign resp_err_o      = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (grant) state_nxt = LOOKUP;
      LOOKUP: begin
        if (lkp_resp_valid_i) begin
          state_nxt = (full_resp && !retry_exhausted) ? RETRY : RESP;
        end
      end
      // gap_cnt reaches 0 on the transition, giving RETRY_GAP idle cycles.
      RETRY:  if (gap_cnt <= 4'd1) state_nxt = LOOKUP;
      RESP:   if (resp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr      <= '0;
      cap_tag     <= '0;
      cap_offset  <= 1'b0;
      cap_id      <= '0;
      cap_hit     <= 1'b0;
      cap_way     <= 3'd0;
      gap_cnt     <= 4'd0;
      rel_valid_o <= 1'b0;
      rel_way_o   <= 3'd0;
    end else begin
      if (grant) begin
        cap_tag    <= req_tag_i[int'(grant_idx)*22 +: 22];
        cap_offset <= req_offset_i[grant_idx];
        cap_id     <= grant_idx;
        rr_ptr     <= grant_idx + IDW'(1);
      end
      if (state == LOOKUP && lkp_resp_valid_i) begin
        if (full_resp && !retry_exhausted) begin
          gap_cnt <= 4'(RETRY_GAP);
        end else if (full_resp) begin
          cap_hit <= 1'b0;
          cap_way <= 3'd0;
        end else begin
          cap_hit <= lkp_resp_hit_i;
          cap_way <= lkp_resp_way_i;
        end
      end
      if (state == RETRY) begin
        gap_cnt <= gap_cnt - 4'd1;
      end
      rel_valid_o <= rel_accept;
      if (rel_accept) begin
        rel_way_o <= rel_way_i;
      end
    end
  end

  always_comb begin
    req_ready_o  = grant ? (NUM_REQ'(1) << grant_idx) : '0;
    rel_ready_o  = rel_accept;
    lkp_valid_o  = (state == LOOKUP);
    lkp_tag_o    = cap_tag;
    lkp_offset_o = cap_offset;
    resp_valid_o = (state == RESP);
    resp_id_o    = cap_id;
    resp_hit_o   = cap_hit;
    resp_way_o   = cap_way;
  end

endmodule

// File: doc/bank_htu_req_arb.md
# bank_htu_req_arb

Request controller in front of one bank's HTU set-status block. Accepts lookup/allocate requests from `NUM_REQ` requesters with round-robin arbitration, issues one lookup at a time to the set-status interface, and re-issues on "set full" after a back-off. Forwards way-release requests, which free reference counts, to the set-status block. Returns hit/way results to the winning requester.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; power of two, 2..8. `IDW = $clog2(NUM_REQ)`.
- `RETRY_GAP`, 4: idle cycles between a "full" response and the re-issue; 1..15.
- `MAX_RETRY`, 15: retry limit. Used only with `HTU_ARB_RETRY_LIMIT_EN`.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `req_valid_i`  in  NUM_REQ  per-requester request valid.
- `req_tag_i`  in  NUM_REQ*22  per-requester tag (address bits 31:10). Requester i occupies bits [22i+21:22i].
- `req_offset_i`  in  NUM_REQ  per-requester offset bit.
- `req_ready_o`  out  NUM_REQ  one-hot accept.
- `lkp_valid_o`  out  1  lookup to set status.
- `lkp_tag_o`  out  22  lookup tag.
- `lkp_offset_o`  out  1  lookup offset.
- `lkp_resp_valid_i`  in  1  set-status response valid.
- `lkp_resp_hit_i`  in  1  tag hit.
- `lkp_resp_full_i`  in  1  miss and no way allocatable (all ways have non-zero reference count).
- `lkp_resp_way_i`  in  3  hit or allocated way.
- `rel_valid_i`  in  1  release request.
- `rel_way_i`  in  3  way to release.
- `rel_ready_o`  out  1  release accepted.
- `rel_valid_o`  out  1  release pulse to set status.
- `rel_way_o`  out  3  released way.
- `resp_valid_o`  out  1  result valid.
- `resp_id_o`  out  IDW  requester index.
- `resp_hit_o`  out  1  hit, not allocate.
- `resp_way_o`  out  3  way.
- `resp_err_o`  out  1  retry limit exhausted.
- `resp_ready_i`  in  1  result consumed.

## Operation
States: IDLE, LOOKUP, RETRY, RESP.

**IDLE**
- If `rel_valid_i`, assert `rel_ready_o`. No grant is made this cycle.
- Otherwise, grant the first valid requester found scanning from `rr_ptr` upward with wrap-around. Assert its `req_ready_o` bit.
- On a grant: capture the tag, offset and id; set `rr_ptr = grant+1` mod `NUM_REQ`; clear the retry count; go to LOOKUP.

**LOOKUP**
- `lkp_valid_o=1` with the captured tag and offset. These are stable until `lkp_resp_valid_i` is sampled high.
- Response with `full=0`: capture hit and way, go to RESP.
- Response with `full=1`: increment the retry count, load the gap counter with `RETRY_GAP`, go to RETRY.

**RETRY**
- The gap counter decrements each cycle. At 0, go to LOOKUP.
- Releases are accepted in this state with the same rule as IDLE. This lets a release free a way and prevents deadlock.

**RESP**
- `resp_valid_o=1`. Id, hit, way and err are stable until `resp_ready_i`.
- On `resp_ready_i`, go to IDLE.

**Release path**
- An accepted release produces `rel_valid_o=1` for exactly one cycle, on the next cycle, with the registered `rel_way_o`.
- `rel_ready_o=0` in LOOKUP and RESP.

**Other rules**
- `req_ready_o` is 0 outside IDLE.
- Requester inputs are ignored while not granted.
- A request that is not granted must stay asserted; it is never dropped.

## Timing
- Reset values: all outputs 0, state IDLE, `rr_ptr=0`, all counters 0.
- Grant in cycle T → `lkp_valid_o` high in T+1.
- Response sampled in cycle L → `resp_valid_o` high in L+1.
- Back-off: `full` sampled in cycle L → `lkp_valid_o` low for `RETRY_GAP` cycles, high again in L+1+`RETRY_GAP`.
- `resp_ready_i` in cycle R → IDLE in R+1; the next grant is possible in R+1.
- Minimum request-to-response: 3 cycles with a same-cycle set-status response. Throughput: one request per 3 cycles.
- Reset in any state: the in-flight request is dropped with no response, and a pending `rel_valid_o` is suppressed.

## Configuration
- `HTU_ARB_RETRY_LIMIT_EN` defined:
  - A 4-bit retry counter is compiled in.
  - A `full` response when the count already equals `MAX_RETRY` goes to RESP with `resp_err_o=1`, `resp_hit_o=0`, `resp_way_o=0`.
- Not defined:
  - Retries are unbounded and no retry counter exists.
  - `resp_err_o` is tied to 0.

## Test plan
- Single requester 2: tag 0x12345, offset 1, set status answers hit way 5 in the same cycle → `lkp_valid_o` at T+1 with the same tag/offset; `resp_valid_o` at T+2 with id=2, hit=1, way=5.
- All four requesters valid continuously, `resp_ready_i=1` → grant order 0,1,2,3,0; `rr_ptr` wraps; no requester starved.
- Full response, `RETRY_GAP=4` → `lkp_valid_o` low for exactly 4 cycles, then reissued. Next response miss/alloc way 3 → hit=0, way=3.
- `rel_valid_i` with way 6 and `req_valid_i` set, both in IDLE → `rel_ready_o=1`, no grant that cycle, `rel_valid_o` pulses one cycle with way 6, grant on the following cycle. Repeat during RETRY → release accepted there too.
- With the macro and `MAX_RETRY=2`, set status always full → 2 retries, then response err=1. Without the macro → retries continue, `resp_err_o` stays 0.
- Assert `rst_i` during LOOKUP and during RESP → all outputs 0 the next cycle; no stale response after reset.
